// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel receiver.
package serial_to_parallel_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } rx_state_t;

   localparam int RX_WIDTH_DEFAULT = 8;
   localparam int RX_CNT_W         = $clog2(RX_WIDTH_DEFAULT);

   function automatic int rx_cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_to_parallel_rx_holder.sv
// Output word register with valid/ready handshake and sticky overflow flag.
module rx_output_holder
   import serial_to_parallel_rx_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic             overflow
);

   logic accept;
   logic can_load;
   logic drop;

   assign accept   = valid & ready;
   assign can_load = ~valid | ready;
   assign drop     = load & ~can_load;

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= INITIAL_VALUE;
         valid <= 1'b0;
      end else if (load && can_load) begin
         q     <= word;
         valid <= 1'b1;
      end else if (accept) begin
         valid <= 1'b0;
      end
   end

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_err) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// MSB-first deserialiser framed by SYNC; hands complete words to the output holder.
//   state | meaning
//   IDLE  | waiting for a SYNC-qualified first bit
//   SHIFT | word partially received, collecting remaining bits
module serial_to_parallel_rx
   import serial_to_parallel_rx_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SDI,
   input  logic             CE,
   input  logic             SYNC,
   output logic [WIDTH-1:0] Q,
   output logic             VALID,
   input  logic             READY,
   output logic             BUSY,
   output logic             OVERFLOW,
   output logic             FRAME_ERR,
   input  logic             CLR_ERR
);

   localparam int CNT_W = rx_cnt_width(WIDTH);

   rx_state_t        state;
   rx_state_t        state_next;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] word;
   logic             start;
   logic             resync;
   logic             advance;
   logic             complete;

   assign word = {shreg[WIDTH-2:0], SDI};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (CE && SYNC) state_next = SHIFT;
         SHIFT:   if (CE && !SYNC && count == CNT_W'(WIDTH-1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // SYNC outranks completion: a SYNC on what would be the last bit restarts the word.
   always_comb begin
      start    = 1'b0;
      resync   = 1'b0;
      advance  = 1'b0;
      complete = 1'b0;
      case (state)
         IDLE: start = CE & SYNC;
         SHIFT: begin
            resync   = CE & SYNC;
            complete = CE & ~SYNC & (count == CNT_W'(WIDTH-1));
            advance  = CE & ~SYNC & (count != CNT_W'(WIDTH-1));
         end
         default: ;
      endcase
   end

   assign BUSY = (state == SHIFT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         shreg <= INITIAL_VALUE;
         count <= '0;
      end else if (start || resync) begin
         shreg <= word;
         count <= CNT_W'(1);
      end else if (advance) begin
         shreg <= word;
         count <= count + CNT_W'(1);
      end else if (complete) begin
         shreg <= word;
         count <= '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         FRAME_ERR <= 1'b0;
      end else if (resync) begin
         FRAME_ERR <= 1'b1;
      end else if (CLR_ERR) begin
         FRAME_ERR <= 1'b0;
      end
   end

   rx_output_holder #(
      .WIDTH         (WIDTH),
      .INITIAL_VALUE (INITIAL_VALUE)
   ) u_holder (
      .clk      (CLK),
      .rst      (RST),
      .load     (complete),
      .word     (word),
      .ready    (READY),
      .clr_err  (CLR_ERR),
      .q        (Q),
      .valid    (VALID),
      .overflow (OVERFLOW)
   );

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx with WIDTH=8.
module tb_serial_to_parallel_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       SDI;
   logic       CE;
   logic       SYNC;
   logic [7:0] Q;
   logic       VALID;
   logic       READY;
   logic       BUSY;
   logic       OVERFLOW;
   logic       FRAME_ERR;
   logic       CLR_ERR;

   int errors = 0;
   int checks = 0;

   serial_to_parallel_rx #(.WIDTH(8), .INITIAL_VALUE(8'h00)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .SDI       (SDI),
      .CE        (CE),
      .SYNC      (SYNC),
      .Q         (Q),
      .VALID     (VALID),
      .READY     (READY),
      .BUSY      (BUSY),
      .OVERFLOW  (OVERFLOW),
      .FRAME_ERR (FRAME_ERR),
      .CLR_ERR   (CLR_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One CE-qualified bit per call, followed by 'gap' idle cycles.
   task automatic send_bit(input logic b, input logic s, input int gap);
      CE = 1'b1; SYNC = s; SDI = b;
      tick();
      CE = 1'b0; SYNC = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7, gap);
   endtask

   initial begin
      RST = 1'b1; SDI = 1'b0; CE = 1'b0; SYNC = 1'b0; READY = 1'b1; CLR_ERR = 1'b0;
      tick(); tick();
      check("rst_q", Q, 8'h00);
      check("rst_valid", VALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_ferr", FRAME_ERR, 0);
      RST = 1'b0;
      tick();

      // 0xA5, one bit per cycle, READY high
      send_bit(1'b1, 1'b1, 0);
      check("a5_busy_first", BUSY, 1);
      check("a5_valid_early", VALID, 0);
      for (int i = 6; i >= 1; i--) send_bit(((8'hA5 >> i) & 8'h01) != 0, 1'b0, 0);
      check("a5_valid_before_last", VALID, 0);
      send_bit(1'b1, 1'b0, 0);
      check("a5_q", Q, 8'hA5);
      check("a5_valid", VALID, 1);
      check("a5_busy_done", BUSY, 0);
      tick();
      check("a5_valid_drop", VALID, 0);
      check("a5_q_hold", Q, 8'hA5);

      // 0x3C, CE every third cycle, READY low
      READY = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         send_bit(((8'h3C >> i) & 8'h01) != 0, i == 7, 2);
         check("3c_busy_mid", BUSY, 1);
      end
      send_bit(1'b0, 1'b0, 0);
      check("3c_q", Q, 8'h3C);
      check("3c_valid", VALID, 1);
      check("3c_busy_done", BUSY, 0);
      repeat (10) tick();
      check("3c_valid_held", VALID, 1);
      check("3c_q_held", Q, 8'h3C);
      READY = 1'b1;
      tick();
      check("3c_valid_drop", VALID, 0);

      // 0x12 then 0x34 with READY low -> overflow; clear in same cycle as set loses
      READY = 1'b0;
      send_word(8'h12, 0);
      check("12_q", Q, 8'h12);
      check("12_valid", VALID, 1);
      CLR_ERR = 1'b1;
      send_word(8'h34, 0);
      CLR_ERR = 1'b0;
      check("34_q_kept", Q, 8'h12);
      check("34_ovf", OVERFLOW, 1);
      check("34_valid", VALID, 1);
      READY = 1'b1;
      tick();
      check("ovf_valid_drop", VALID, 0);
      check("ovf_sticky", OVERFLOW, 1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("ovf_clear", OVERFLOW, 0);

      // 4 bits 1011, then SYNC with 0xF0
      send_bit(1'b1, 1'b1, 0);
      send_bit(1'b0, 1'b0, 0);
      send_bit(1'b1, 1'b0, 0);
      send_bit(1'b1, 1'b0, 0);
      check("ferr_partial_busy", BUSY, 1);
      check("ferr_before", FRAME_ERR, 0);
      send_bit(1'b1, 1'b1, 0);
      check("ferr_set", FRAME_ERR, 1);
      check("ferr_busy", BUSY, 1);
      for (int i = 6; i >= 0; i--) send_bit(((8'hF0 >> i) & 8'h01) != 0, 1'b0, 0);
      check("f0_q", Q, 8'hF0);
      check("f0_valid", VALID, 1);
      check("f0_ferr_sticky", FRAME_ERR, 1);
      tick();
      check("f0_valid_drop", VALID, 0);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("ferr_clear", FRAME_ERR, 0);

      // stray bits in IDLE without SYNC
      for (int i = 0; i < 6; i++) send_bit(i[0], 1'b0, 0);
      check("stray_busy", BUSY, 0);
      check("stray_valid", VALID, 0);
      check("stray_q", Q, 8'hF0);
      check("stray_ferr", FRAME_ERR, 0);

      // reset after 5 bits of 0x81, then clean 0x81
      for (int i = 7; i >= 3; i--) send_bit(((8'h81 >> i) & 8'h01) != 0, i == 7, 0);
      check("81_partial_busy", BUSY, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("81_rst_q", Q, 8'h00);
      check("81_rst_valid", VALID, 0);
      check("81_rst_busy", BUSY, 0);
      check("81_rst_ovf", OVERFLOW, 0);
      check("81_rst_ferr", FRAME_ERR, 0);
      send_word(8'h81, 0);
      check("81_q", Q, 8'h81);
      check("81_valid", VALID, 1);
      check("81_busy", BUSY, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
